// File: rtl/sigmoid_lut_result_stage.sv
// rtl/sigmoid_lut_result_stage.sv - sigmoid LUT read, S7.8 result reconstruction and 3-entry output FIFO
module sigmoid_lut_result_stage #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    FRAC_BITS  = 8,
  parameter logic [DATA_WIDTH-1:0] SAT_VALUE  = 16'h00FF,
  parameter int                    TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_addr_valid,
  input  logic                  in_use_symmetry,
  input  logic                  in_saturate_high,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  lut_rd_en,
  output logic [ADDR_WIDTH-1:0] lut_rd_addr,
  input  logic [DATA_WIDTH-1:0] lut_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam int DEPTH = 3;

  logic                  acc;
  logic                  eff_sat;
  logic                  push;
  logic                  pop;
  logic                  valid1;
  logic                  sym1;
  logic                  sat1;
  logic [TAG_WIDTH-1:0]  tag1;
  logic [DATA_WIDTH-1:0] y1;
  logic [DATA_WIDTH-1:0] r1;
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            count;
  logic [2:0]            occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Items in stage 1 plus items buffered; admitting only below 3 means a push never hits a full FIFO.
  assign occupancy = {1'b0, count} + {2'b0, valid1};
  assign in_ready  = ~rst & (occupancy < 3'd3);
  assign acc       = in_valid & in_ready;

  // Out-of-range addresses are folded into saturation and skip the LUT read.
  assign eff_sat     = in_saturate_high | ~in_addr_valid;
  assign lut_rd_en   = acc & ~eff_sat;
  assign lut_rd_addr = in_addr;

  // Stage 1 holds the request attributes while the LUT data is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1 <= 1'b0;
      sym1   <= 1'b0;
      sat1   <= 1'b0;
      tag1   <= '0;
    end else begin
      valid1 <= acc;
      if (acc) begin
        sym1 <= in_use_symmetry;
        sat1 <= eff_sat;
        tag1 <= in_tag;
      end
    end
  end

  // Reconstruct the sigmoid: saturation or clamped LUT value, mirrored to 1-y for negative inputs.
  always_comb begin
    y1 = lut_rd_data;
    if (sat1) begin
      y1 = SAT_VALUE;
    end else if (lut_rd_data > ONE) begin
      y1 = ONE;
    end
    r1 = sym1 ? (ONE - y1) : y1;
  end

  assign push      = valid1;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_tag   = out_valid ? fifo_tag[rd_ptr] : '0;
  assign busy      = valid1 | out_valid;

  // First-word-fall-through FIFO with mod-3 pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
      end
    end else begin
      assert (!(push && !pop && count == 2'd3));
      if (push) begin
        fifo_data[wr_ptr] <= r1;
        fifo_tag[wr_ptr]  <= tag1;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_result_stage.sv
// tb/tb_sigmoid_lut_result_stage.sv - self-checking bench for sigmoid_lut_result_stage
module tb_sigmoid_lut_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_addr;
  logic        in_addr_valid;
  logic        in_use_symmetry;
  logic        in_saturate_high;
  logic [3:0]  in_tag;
  logic        lut_rd_en;
  logic [10:0] lut_rd_addr;
  logic [15:0] lut_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
    int          rdy;
  } ent_t;
  ent_t q[$];

  sigmoid_lut_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_addr_valid(in_addr_valid),
    .in_use_symmetry(in_use_symmetry), .in_saturate_high(in_saturate_high),
    .in_tag(in_tag),
    .lut_rd_en(lut_rd_en), .lut_rd_addr(lut_rd_addr), .lut_rd_data(lut_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // LUT contents seen by the bench.
  function automatic int lut_fn(input logic [10:0] a);
    case (a)
      11'h000: return 128;
      11'h200: return 200;
      11'h300: return 300;
      11'h301: return 16'h8000;
      default: return int'(a[7:0]);
    endcase
  endfunction

  // External synchronous LUT with 1-cycle latency; junk when not read.
  always @(posedge clk) begin
    if (lut_rd_en) lut_rd_data <= 16'(lut_fn(lut_rd_addr));
    else           lut_rd_data <= 16'hDEAD;
  end

  // Expected sigmoid value straight from the rules.
  function automatic logic [15:0] model_val(input logic [10:0] a, input logic av,
                                            input logic sym, input logic sat);
    int y;
    if (sat || !av) y = 255;
    else begin
      y = lut_fn(a);
      if (y > 256) y = 256;
    end
    if (sym) y = 256 - y;
    return 16'(y);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction-level model.
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    logic exp_en;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_lut_rd_en", lut_rd_en, 0);
      chk("rst_busy", busy, 0);
      q.delete();
    end else begin
      exp_ready = (q.size() < 3);
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, q.size() != 0);
      exp_valid = 1'b0;
      if (q.size() != 0) exp_valid = (q[0].rdy <= cyc);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", out_tag, q[0].t);
      end
      exp_en = in_valid && exp_ready && !(in_saturate_high || !in_addr_valid);
      chk("lut_rd_en", lut_rd_en, exp_en);
      if (exp_en) chk("lut_rd_addr", lut_rd_addr, in_addr);
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready)
        q.push_back('{model_val(in_addr, in_addr_valid, in_use_symmetry, in_saturate_high),
                      in_tag, cyc + 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; reports cycles spent and whether a LUT read was issued.
  task automatic send(input logic [10:0] a, input logic av, input logic sym, input logic sat,
                      input logic [3:0] t, output int waited, output logic en_seen);
    logic a_ok;
    logic done;
    in_valid = 1'b1; in_addr = a; in_addr_valid = av;
    in_use_symmetry = sym; in_saturate_high = sat; in_tag = t;
    waited = 0; done = 1'b0; en_seen = 1'b0;
    while (!done) begin
      @(negedge clk);
      a_ok    = in_ready;
      en_seen = lut_rd_en;
      tick();
      waited++;
      if (a_ok) done = 1'b1;
      else if (waited >= 40) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  // One isolated request with a literal expected result and exact 2-cycle latency.
  task automatic single(input string nm, input logic [10:0] a, input logic av, input logic sym,
                        input logic sat, input logic [3:0] t, input logic exp_en,
                        input logic [15:0] exp_d);
    int   w;
    logic en;
    send(a, av, sym, sat, t, w, en);
    in_valid = 1'b0;
    chk({nm, "_rd_en"}, en, exp_en);
    chk({nm, "_wait"}, w, 1);
    @(negedge clk);
    chk({nm, "_early"}, out_valid, 0);
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, exp_d);
    chk({nm, "_tag"}, out_tag, t);
    tick();
  endtask

  initial begin
    int          w;
    logic        en;
    int          nacc;
    logic [3:0]  bt;
    logic        have;
    logic [15:0] held;
    logic        a_ok;

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_addr_valid = 1'b1;
    in_use_symmetry = 1'b0; in_saturate_high = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_reset_in_ready", in_ready, 1);

    single("basic",     11'h000, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 16'h0080);
    single("sym",       11'h200, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1, 16'h0038);
    single("sat",       11'h123, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 16'h00FF);
    single("sat_sym",   11'h123, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0, 16'h0001);
    single("inv",       11'h045, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 16'h00FF);
    single("inv_sym",   11'h045, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'h0001);
    single("clamp",     11'h300, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 16'h0100);
    single("clamp_sym", 11'h300, 1'b1, 1'b1, 1'b0, 4'hC, 1'b1, 16'h0000);
    single("clamp_big", 11'h301, 1'b1, 1'b0, 1'b0, 4'hD, 1'b1, 16'h0100);

    // Streaming: 8 back-to-back, never stalled.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(11'(i * 3 + 16), 1'b1, i[0], (i == 5), 4'(i), w, en);
      chk("stream_wait", w, 1);
    end
    in_valid = 1'b0;
    repeat (6) tick();

    // Backpressure: only 3 admitted, head held stable.
    out_ready = 1'b0; in_valid = 1'b1; bt = 4'd0; nacc = 0; have = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) begin
      in_addr = 11'(8'h40 + bt); in_addr_valid = 1'b1; in_use_symmetry = bt[0];
      in_saturate_high = 1'b0; in_tag = bt;
      @(negedge clk);
      a_ok = in_ready;
      if (out_valid) begin
        if (have) chk("bp_hold", out_data, held);
        else begin held = out_data; have = 1'b1; end
      end
      tick();
      if (a_ok) begin nacc++; bt++; end
    end
    chk("bp_accepts", nacc, 3);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_first_head", held, 16'h0040);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_addr = 11'(8'h40 + bt); in_use_symmetry = bt[0]; in_tag = bt;
      @(negedge clk);
      a_ok = in_ready;
      tick();
      if (a_ok) bt++;
    end
    in_valid = 1'b0;
    chk("bp_resumed", (bt > 4'd3), 1);
    repeat (6) tick();

    // Reset with two buffered results and one in stage 1.
    out_ready = 1'b0;
    send(11'h010, 1'b1, 1'b0, 1'b0, 4'd1, w, en);
    send(11'h011, 1'b1, 1'b0, 1'b0, 4'd2, w, en);
    send(11'h012, 1'b1, 1'b0, 1'b0, 4'd3, w, en);
    in_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("after_rst_busy", busy, 0);
    chk("after_rst_out_valid", out_valid, 0);

    single("post_rst", 11'h200, 1'b1, 1'b0, 1'b0, 4'hE, 1'b1, 16'h00C8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/sigmoid_lut_result_stage.md
Name: sigmoid_lut_result_stage

Overview:
- Consumer side of the sigmoid address calculator.
- Accepts {lut_addr, addr_valid, use_symmetry, saturate_high, tag} requests through a valid/ready handshake.
- Issues the read to the external synchronous sigmoid LUT (fixed 1-cycle read latency).
- Reconstructs the final sigmoid value in S7.8 (saturation, clamp, symmetry 1−y), buffers it in a 3-entry FIFO and presents it to the LSTM gate datapath under valid/ready.

Parameters:
DATA_WIDTH, 16, width of LUT data and output (S7.8)
ADDR_WIDTH, 11, LUT address width
FRAC_BITS, 8, fractional bits; ONE = 1<<FRAC_BITS = 256
SAT_VALUE, 16'h00FF, result used for positive saturation (sigmoid(>6) ≈ 255/256)
TAG_WIDTH, 4, sideband tag carried with each request

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_addr  in  ADDR_WIDTH  LUT address from address calculator
in_addr_valid  in  1  address within LUT range
in_use_symmetry  in  1  input was negative
in_saturate_high  in  1  |x| above LUT range
in_tag  in  TAG_WIDTH  sideband tag
lut_rd_en  out  1  LUT read strobe
lut_rd_addr  out  ADDR_WIDTH  LUT read address
lut_rd_data  in  DATA_WIDTH  LUT data, valid 1 cycle after lut_rd_en
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  sigmoid result, S7.8, range [0, 256]
out_tag  out  TAG_WIDTH  tag of result
busy  out  1  any request in flight or buffered

Behaviour:
- Reset (async, active-high):
  - valid1, FIFO count, read/write pointers = 0.
  - out_valid = 0, out_data = 0, out_tag = 0, lut_rd_en = 0, busy = 0.
  - in_ready = 0 while rst is high.
- Accept: acc = in_valid & in_ready.
- Effective saturation: eff_sat = in_saturate_high | ~in_addr_valid.
- Stage 0 (combinational):
  - lut_rd_en = acc & ~eff_sat.
  - lut_rd_addr = in_addr, passed straight through.
  - Saturated requests issue no LUT read but still occupy the pipeline, so ordering is preserved.
- Stage 1 register: on acc, capture valid1 = 1, sym1, sat1 = eff_sat, tag1. Without acc, valid1 = 0.
- Stage 1 compute (combinational, when valid1):
  - y = sat1 ? SAT_VALUE : min(lut_rd_data, ONE). Compare lut_rd_data unsigned; any value > 256 clamps to 256.
  - r = sym1 ? ONE − y : y. No underflow is possible because y ≤ ONE.
  - Write {r, tag1} into the FIFO at the end of the cycle.
- FIFO:
  - Depth 3, first-word-fall-through.
  - out_valid = (count != 0); out_data/out_tag = head entry.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo 3.
- Flow control: in_ready = ~rst & ((count + valid1) < 3).
  - in_ready has no combinational dependence on out_ready.
  - This guarantees a push never meets a full FIFO; overflow is impossible by construction and should be covered by an assertion.
- Latency: acceptance in cycle N → out_valid in cycle N+2 (FIFO initially empty).
  - Sustained throughput is 1 result/cycle while out_ready = 1.
- Backpressure with out_ready held low:
  - At most 3 results are stored.
  - in_ready falls once count + valid1 reaches 3.
  - It rises again in the cycle after the first pop.
- Output stability: while out_valid & ~out_ready, out_data and out_tag hold unchanged.
- busy = valid1 | (count != 0).
- Reset mid-operation: all in-flight and buffered results are discarded; no output appears after reset deasserts until a new request is accepted.
- Data is treated as unsigned magnitude; sign handling is solely via in_use_symmetry.

Test Plan:
- Single request, addr = 0x000, sym = 0, sat = 0, lut_rd_data = 128:
  - lut_rd_en = 1 with addr 0 in cycle N.
  - out_valid in N+2 with out_data = 0x0080, tag echoed.
- Symmetry, addr = 0x0200, sym = 1, lut_rd_data = 200:
  - out_data = 56 (0x0038).
- Saturation, sat = 1, sym = 0:
  - No lut_rd_en pulse; out_data = 0x00FF.
- Saturation, sat = 1, sym = 1:
  - out_data = 0x0001.
- Invalid address, in_addr_valid = 0, sat = 0:
  - Treated as saturated, same responses as the saturation cases.
- Clamp, lut_rd_data = 300:
  - sym = 0 → out_data = 0x0100.
  - sym = 1 → out_data = 0x0000.
- Streaming: 8 back-to-back requests with tags 0..7 and out_ready = 1:
  - in_ready stays 1.
  - Results are consecutive in cycles N+2..N+9, tags in order.
- Backpressure: out_ready = 0, continuous in_valid:
  - Exactly 3 requests accepted; in_ready = 0 thereafter; outputs held stable.
  - Raise out_ready → 3 results drain in order, then accepting resumes.
- Reset mid-stream: assert rst while count = 2 and valid1 = 1:
  - Outputs go to reset values immediately.
  - After release, no stale result appears; busy = 0.
